// File: rtl/chrom_eval_pkg.sv
// Shared constants for the chromosome evaluation sequencer: register map,
// CTRL/status bit positions and FSM state encodings.
package chrom_eval_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_COUNT    = 2'd1;
  localparam logic [1:0] ADDR_BEST_SUM = 2'd2;
  localparam logic [1:0] ADDR_BEST_IDX = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CLEAR  = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_IRQ_EN  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LAUNCH  = 2'd1;
  localparam state_t ST_WAIT    = 2'd2;
  localparam state_t ST_CAPTURE = 2'd3;

endpackage

// File: rtl/chrom_eval_sequencer_if.sv
// Avalon-MM slave port of the sequencer register file, as seen by the Nios CPU.
interface chrom_eval_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/chrom_eval_best_tracker.sv
// Keeps the smallest error sum seen in a run and the index that produced it.
module chrom_eval_best_tracker
  import chrom_eval_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             capture,
  input  logic [31:0]      sum,
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      best_sum,
  output logic [IDX_W-1:0] best_idx
);

  // Strict compare: on a tie the earlier (lower) index is retained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_sum <= '1;
      best_idx <= '0;
    end else if (clear) begin
      best_sum <= '1;
      best_idx <= '0;
    end else if (capture && (sum < best_sum)) begin
      best_sum <= sum;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/chrom_eval_sequencer.sv
// Runs one evaluator start/done handshake per chromosome and reports the
// minimum error sum and its index through a 4-word register file.
module chrom_eval_sequencer
  import chrom_eval_pkg::*;
#(
  parameter int NUM_CHROM = 16,
  parameter int IDX_W     = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  chrom_eval_sequencer_if.slave bus,
  output logic                  eval_start,
  output logic [IDX_W-1:0]      eval_chrom_idx,
  input  logic                  eval_done,
  input  logic [31:0]           error_sum_in,
  output logic                  irq
);

  localparam int CNT_W = IDX_W + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count, run_count, wr_count;
  logic [31:0]        sum_q, best_sum, rd_mux;
  logic [IDX_W-1:0]   best_idx;
  logic               done, timeout, irq_en, busy;
  logic               done_nxt, timeout_nxt, irq_en_nxt;
  logic               wr_en, ctrl_wr, cnt_wr;
  logic               do_start, do_abort, do_clear, last, done_set, tmo_set, capture;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign ctrl_wr  = wr_en && (bus.address == ADDR_CTRL);
  assign cnt_wr   = wr_en && (bus.address == ADDR_COUNT);
  assign busy     = (state != ST_IDLE);
  assign do_abort = ctrl_wr && bus.writedata[CTRL_ABORT] && busy;
  assign do_start = ctrl_wr && bus.writedata[CTRL_START] && !bus.writedata[CTRL_ABORT] && !busy;
  assign do_clear = ctrl_wr && bus.writedata[CTRL_CLEAR];
  assign wr_count = (bus.writedata > 32'(NUM_CHROM)) ? CNT_W'(NUM_CHROM) : bus.writedata[IDX_W:0];
  assign last     = ({1'b0, idx} == (run_count - 1'b1));
  assign capture  = (state == ST_CAPTURE) && !do_abort;
  assign done_set = (do_start && (count == '0)) || (capture && last);
  assign tmo_set  = (state == ST_WAIT) && !do_abort && !eval_done && (timer == '0);

  assign eval_start     = (state == ST_LAUNCH);
  assign eval_chrom_idx = idx;

  // Set beats clear; a new start also wipes the previous run's flags.
  assign done_nxt    = done_set ? 1'b1 : ((do_clear || do_start) ? 1'b0 : done);
  assign timeout_nxt = tmo_set  ? 1'b1 : ((do_clear || do_start) ? 1'b0 : timeout);
  assign irq_en_nxt  = ctrl_wr  ? bus.writedata[CTRL_IRQ_EN] : irq_en;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (do_start && (count != '0)) state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (eval_done)          state_nxt = ST_CAPTURE;
        else if (timer == '0)   state_nxt = ST_IDLE;
      end
      default:    state_nxt = last ? ST_IDLE : ST_LAUNCH;
    endcase
    if (do_abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_CTRL: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = done;
        rd_mux[STAT_TIMEOUT] = timeout;
        rd_mux[STAT_IRQ_EN]  = irq_en;
      end
      ADDR_COUNT:    rd_mux[CNT_W-1:0] = count;
      ADDR_BEST_SUM: rd_mux = best_sum;
      default:       rd_mux[IDX_W-1:0] = best_idx;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      idx          <= '0;
      run_count    <= '0;
      sum_q        <= '0;
      count        <= CNT_W'(NUM_CHROM);
      done         <= 1'b0;
      timeout      <= 1'b0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      state        <= state_nxt;
      done         <= done_nxt;
      timeout      <= timeout_nxt;
      irq_en       <= irq_en_nxt;
      irq          <= done_nxt & irq_en_nxt;
      bus.readdata <= rd_mux;
      if (cnt_wr) count <= wr_count;
      // The run works from a snapshot so COUNT writes mid-run only affect the next run.
      if (do_start) begin
        idx       <= '0;
        run_count <= count;
      end else if (capture && !last) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_LAUNCH)    timer <= TMR_W'(TIMEOUT - 1);
      else if (state == ST_WAIT) timer <= timer - 1'b1;
      if ((state == ST_WAIT) && eval_done && !do_abort) sum_q <= error_sum_in;
    end
  end

  chrom_eval_best_tracker #(.IDX_W(IDX_W)) u_best (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (do_start),
    .capture  (capture),
    .sum      (sum_q),
    .idx      (idx),
    .best_sum (best_sum),
    .best_idx (best_idx)
  );

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Bench for chrom_eval_sequencer: randomized evaluator responses checked
// against an array-based min/argmin model of each run.
module tb_chrom_eval_sequencer;
  import chrom_eval_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        eval_start, irq, eval_done;
  logic [3:0]  eval_chrom_idx;
  logic [31:0] error_sum_in;
  logic        resp_done = 1'b0, man_done = 1'b0, resp_en = 1'b1;
  logic [31:0] resp_data = '0, man_sum = '0;
  logic [31:0] sums [16];
  int          starts_q [$];
  int          n_checks = 0, n_fail = 0;

  chrom_eval_sequencer_if bus ();

  assign eval_done    = resp_done | man_done;
  assign error_sum_in = man_done ? man_sum : resp_data;

  chrom_eval_sequencer dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .eval_start(eval_start),
    .eval_chrom_idx(eval_chrom_idx), .eval_done(eval_done),
    .error_sum_in(error_sum_in), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_n && eval_start) starts_q.push_back(int'(eval_chrom_idx));

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Evaluator stand-in: answers each start after a random latency.
  initial begin
    int d, k;
    forever begin
      @(negedge clk);
      if (eval_start && resp_en) begin
        d = $urandom_range(1, 5);
        k = int'(eval_chrom_idx);
        repeat (d) @(negedge clk);
        resp_done = 1'b1;
        resp_data = sums[k];
        @(negedge clk);
        resp_done = 1'b0;
        resp_data = $urandom;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(posedge clk);
    #1 d = bus.readdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int budget = 3000;
    do begin
      bus_read(ADDR_CTRL, d);
      budget--;
    end while (d[STAT_BUSY] && budget > 0);
    if (budget == 0) check_eq({tag, "_idle_wait"}, {31'b0, d[STAT_BUSY]}, 32'd0);
  endtask

  // Reference: min of the first n sums; index = first position holding that min.
  function automatic void model_best(input int n, output logic [31:0] bs, output int bi);
    logic [31:0] mn = 32'hFFFF_FFFF;
    bi = 0;
    for (int i = 0; i < n; i++) mn = (sums[i] < mn) ? sums[i] : mn;
    bs = mn;
    if (mn != 32'hFFFF_FFFF)
      for (int i = n - 1; i >= 0; i--) if (sums[i] == mn) bi = i;
  endfunction

  task automatic check_results(input int n, input logic ien, input string tag);
    logic [31:0] d, es;
    int ei;
    model_best(n, es, ei);
    check_eq({tag, "_nstarts"}, starts_q.size(), n);
    foreach (starts_q[i]) check_eq({tag, "_idx_seq"}, starts_q[i], i);
    bus_read(ADDR_BEST_SUM, d); check_eq({tag, "_best_sum"}, d, es);
    bus_read(ADDR_BEST_IDX, d); check_eq({tag, "_best_idx"}, d, ei);
    bus_read(ADDR_CTRL, d);     check_eq({tag, "_ctrl"}, d, {28'b0, ien, 3'b010});
    check_eq({tag, "_irq"}, {31'b0, irq}, {31'b0, ien});
  endtask

  task automatic run_seq(input int n, input logic ien, input string tag);
    starts_q.delete();
    bus_write(ADDR_COUNT, n);
    bus_write(ADDR_CTRL, 32'h1 | (32'(ien) << CTRL_IRQ_EN));
    check_eq({tag, "_start_lat"}, {31'b0, eval_start}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_start_pulse"}, {31'b0, eval_start}, 32'd0);
    wait_idle(tag);
    check_results(n, ien, tag);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    logic ien;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    for (int i = 0; i < 16; i++) sums[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", bus.readdata, 32'd0);
    check_eq("rst_outputs", {29'b0, eval_start, irq, |eval_chrom_idx}, 32'd0);
    reset_n = 1'b1;
    bus_read(ADDR_CTRL, d);     check_eq("rst_ctrl", d, 32'd0);
    bus_read(ADDR_COUNT, d);    check_eq("rst_count", d, 32'd16);
    bus_read(ADDR_BEST_SUM, d); check_eq("rst_best_sum", d, 32'hFFFF_FFFF);
    bus_read(ADDR_BEST_IDX, d); check_eq("rst_best_idx", d, 32'd0);

    sums[0] = 100; sums[1] = 40; sums[2] = 40;
    run_seq(3, 1'b0, "tie");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 16);
      ien = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++)
        sums[i] = (r[0]) ? 32'($urandom_range(0, 7)) : $urandom;
      run_seq(n, ien, "rand");
    end

    // Start and COUNT writes while busy: the running sequence must be unaffected.
    for (int i = 0; i < 16; i++) sums[i] = $urandom;
    starts_q.delete();
    bus_write(ADDR_COUNT, 3);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    bus_write(ADDR_COUNT, 5);
    bus_write(ADDR_CTRL, 32'h1);
    wait_idle("busy");
    check_results(3, 1'b0, "busy");
    bus_read(ADDR_COUNT, d); check_eq("busy_count_stored", d, 32'd5);

    // Abort during idx 1 WAIT with a simultaneous done.
    resp_en = 1'b0;
    starts_q.delete();
    bus_write(ADDR_COUNT, 4);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    man_done = 1'b1; man_sum = 32'd55;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    bus.address = ADDR_CTRL; bus.writedata = 32'h2; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    man_done = 1'b1; man_sum = 32'd1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; man_done = 1'b0;
    bus_read(ADDR_CTRL, d);     check_eq("abort_ctrl", d, 32'd0);
    bus_read(ADDR_BEST_SUM, d); check_eq("abort_best_sum", d, 32'd55);
    bus_read(ADDR_BEST_IDX, d); check_eq("abort_best_idx", d, 32'd0);
    repeat (20) @(negedge clk);
    check_eq("abort_nstarts", starts_q.size(), 2);

    // Evaluator never answers: timeout after exactly TIMEOUT WAIT cycles.
    starts_q.delete();
    bus_write(ADDR_COUNT, 2);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (1023) @(negedge clk);
    bus_read(ADDR_CTRL, d); check_eq("tmo_last_wait", d, 32'h1);
    bus_read(ADDR_CTRL, d); check_eq("tmo_ctrl", d, 32'h4);
    repeat (10) @(negedge clk);
    check_eq("tmo_nstarts", starts_q.size(), 1);
    resp_en = 1'b1;

    sums[0] = 32'd7;
    run_seq(1, 1'b1, "irq");
    bus_write(ADDR_CTRL, 32'hC);
    check_eq("irq_clear", {31'b0, irq}, 32'd0);
    bus_read(ADDR_CTRL, d); check_eq("irq_clear_ctrl", d, 32'h8);
    bus_write(ADDR_CTRL, 32'h0);

    bus_write(ADDR_COUNT, 40);
    bus_read(ADDR_COUNT, d); check_eq("count_clamp", d, 32'd16);
    bus_write(ADDR_COUNT, 16);
    bus_read(ADDR_COUNT, d); check_eq("count_max", d, 32'd16);
    starts_q.delete();
    bus_write(ADDR_COUNT, 0);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus_read(ADDR_CTRL, d);     check_eq("cnt0_ctrl", d, 32'h2);
    bus_read(ADDR_BEST_SUM, d); check_eq("cnt0_best_sum", d, 32'hFFFF_FFFF);
    check_eq("cnt0_nstarts", starts_q.size(), 0);

    // Reset asserted mid-run while waiting on the evaluator.
    resp_en = 1'b0;
    bus_write(ADDR_COUNT, 2);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus.address = ADDR_COUNT;
    @(negedge clk);
    check_eq("mid_pre_readdata", bus.readdata, 32'd2);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_readdata", bus.readdata, 32'd0);
    check_eq("mid_rst_outputs", {30'b0, eval_start, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_BEST_SUM, d); check_eq("mid_best_sum", d, 32'hFFFF_FFFF);
    bus_read(ADDR_COUNT, d);    check_eq("mid_count", d, 32'd16);
    bus_read(ADDR_CTRL, d);     check_eq("mid_ctrl", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
